uart_tx_frame: RTL

//  FPGA-to-host direction of the board UART link: serialises one byte per send request as

---
 rtl/uart_tx_frame.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start + 8 data bits (LSB first) + optional parity + stop bit(s).
// The send request is synchronised and edge-detected, and the frame settings are captured at frame start.
module uart_tx_frame #(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       send,
   input  logic [7:0] data_transmit,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   output logic       tx,
   output logic       tx_active_flag,
   output logic       tx_done_flag
);

   localparam int unsigned DIV_MAX = CLK_FREQ / 2400;
   localparam int unsigned CW      = $clog2(DIV_MAX + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n, div_q, div_sel;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    data_q;
   logic          par_en_q, par_bit_q;
   logic          sync1, sync2, prev, req, load, tick;
   logic          tx_n, active_n, done_n;

   // Flops reset high so that a send held through reset release gives no edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= send;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign req  = sync2 & ~prev;
   assign tick = (baud_cnt == div_q - CW'(1));

   always_comb begin
      case (baud_rate)
         2'b00:   div_sel = CW'(CLK_FREQ / 2400);
         2'b01:   div_sel = CW'(CLK_FREQ / 4800);
         2'b10:   div_sel = CW'(CLK_FREQ / 9600);
         default: div_sel = CW'(CLK_FREQ / 19200);
      endcase
   end

   always_comb begin
      state_n    = state;
      baud_cnt_n = baud_cnt;
      bit_cnt_n  = bit_cnt;
      tx_n       = tx;
      active_n   = tx_active_flag;
      done_n     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            tx_n     = 1'b1;
            active_n = 1'b0;
            if (req) begin
               load       = 1'b1;
               state_n    = START;
               baud_cnt_n = '0;
               bit_cnt_n  = '0;
               tx_n       = 1'b0;
               active_n   = 1'b1;
            end
         end
         default: begin
            if (!tick) begin
               baud_cnt_n = baud_cnt + CW'(1);
            end else begin
               baud_cnt_n = '0;
               case (state)
                  START: begin
                     state_n   = DATA;
                     bit_cnt_n = '0;
                     tx_n      = data_q[0];
                  end
                  DATA: begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        if (par_en_q) begin
                           state_n = PARITY;
                           tx_n    = par_bit_q;
                        end else begin
                           state_n = STOP;
                           tx_n    = 1'b1;
                        end
                     end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = data_q[bit_cnt_n];
                     end
                  end
                  PARITY: begin
                     state_n   = STOP;
                     bit_cnt_n = '0;
                     tx_n      = 1'b1;
                  end
                  default: begin
                     tx_n = 1'b1;
                     if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        state_n   = IDLE;
                        bit_cnt_n = '0;
                        active_n  = 1'b0;
                        done_n    = 1'b1;
                     end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                     end
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         baud_cnt       <= '0;
         bit_cnt        <= '0;
         tx             <= 1'b1;
         tx_active_flag <= 1'b0;
         tx_done_flag   <= 1'b0;
         data_q         <= '0;
         par_en_q       <= 1'b0;
         par_bit_q      <= 1'b0;
         div_q          <= '0;
      end else begin
         state          <= state_n;
         baud_cnt       <= baud_cnt_n;
         bit_cnt        <= bit_cnt_n;
         tx             <= tx_n;
         tx_active_flag <= active_n;
         tx_done_flag   <= done_n;
         if (load) begin
            data_q    <= data_transmit;
            par_en_q  <= ^parity_type;
            par_bit_q <= (parity_type == 2'b01) ? ~^data_transmit : ^data_transmit;
            div_q     <= div_sel;
         end
      end
   end

endmodule
